// File: rtl/sha3_theta_updater_stream_if.sv
// Handshake and bus bundle for the theta-update stream stage.
//   ivalid/iready/bypass/isa..ise/elt : input beat (one or five columns per beat)
//   ovalid/oready/osa..ose            : registered 5x5 output state
//   busy                              : a partial state is staged
// master = upstream/downstream environment, slave = the theta updater.
interface sha3_theta_updater_stream_if #(
  parameter int unsigned LANE_WIDTH = 64,
  parameter int unsigned COLS       = 5
);
  logic                  ivalid;
  logic                  iready;
  logic                  bypass;
  logic [LANE_WIDTH-1:0] isa [COLS];
  logic [LANE_WIDTH-1:0] isb [COLS];
  logic [LANE_WIDTH-1:0] isc [COLS];
  logic [LANE_WIDTH-1:0] isd [COLS];
  logic [LANE_WIDTH-1:0] ise [COLS];
  logic [LANE_WIDTH-1:0] elt [COLS];
  logic                  ovalid;
  logic                  oready;
  logic [LANE_WIDTH-1:0] osa [5];
  logic [LANE_WIDTH-1:0] osb [5];
  logic [LANE_WIDTH-1:0] osc [5];
  logic [LANE_WIDTH-1:0] osd [5];
  logic [LANE_WIDTH-1:0] ose [5];
  logic                  busy;

  modport master (
    output ivalid, bypass, isa, isb, isc, isd, ise, elt, oready,
    input  iready, ovalid, osa, osb, osc, osd, ose, busy
  );

  modport slave (
    input  ivalid, bypass, isa, isb, isc, isd, ise, elt, oready,
    output iready, ovalid, osa, osb, osc, osd, ose, busy
  );
endinterface

// File: rtl/sha3_theta_updater_stream.sv
// Theta update stage: XORs each column's D value into the five lanes of that
// column and registers the full 5x5 state. One state arrives in one beat
// (COLS=5) or column-serially over five beats (COLS=1).
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of sha3_theta_updater_stream_if (input beat, output
//          state, busy)
module sha3_theta_updater_stream #(
  parameter int unsigned LANE_WIDTH = 64,
  parameter int unsigned COLS       = 5
) (
  input logic                        clk,
  input logic                        rst,
  sha3_theta_updater_stream_if.slave bus
);

  localparam int unsigned BEATS = 5 / COLS;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CIW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  // Elaboration-time parameter legality.
  if (LANE_WIDTH != 8 && LANE_WIDTH != 16 && LANE_WIDTH != 32 && LANE_WIDTH != 64) begin : g_bad_lane_width
    $error("sha3_theta_updater_stream: LANE_WIDTH must be 8, 16, 32 or 64");
  end
  if (COLS != 1 && COLS != 5) begin : g_bad_cols
    $error("sha3_theta_updater_stream: COLS must be 1 or 5");
  end

  typedef logic [LANE_WIDTH-1:0] lane_t;

  lane_t         mask   [COLS];
  lane_t         res    [5][COLS];
  lane_t         merged [5][5];
  lane_t         stage  [5][5];
  lane_t         ostate [5][5];
  logic [BW-1:0] beat;
  logic          ovalid_q;
  logic          busy_q;
  logic          last;
  logic          accept;
  logic          consume;

  // Theta applied to the beat's columns; bypass zeroes the D value.
  for (genvar j = 0; j < COLS; j++) begin : g_col
    assign mask[j]   = bus.bypass ? '0 : bus.elt[j];
    assign res[0][j] = bus.isa[j] ^ mask[j];
    assign res[1][j] = bus.isb[j] ^ mask[j];
    assign res[2][j] = bus.isc[j] ^ mask[j];
    assign res[3][j] = bus.isd[j] ^ mask[j];
    assign res[4][j] = bus.ise[j] ^ mask[j];
  end

  // Staged columns with the current beat's columns overlaid at k*COLS+j.
  always_comb begin
    merged = stage;
    for (int j = 0; j < int'(COLS); j++) begin
      for (int r = 0; r < 5; r++) begin
        merged[3'(r)][3'(int'(beat) * int'(COLS) + j)] = res[3'(r)][CIW'(j)];
      end
    end
  end

  assign last    = (beat == LAST_BEAT);
  // Only the final beat needs room in the output register.
  assign bus.iready = !last || !ovalid_q || bus.oready;
  assign accept  = bus.ivalid && bus.iready;
  assign consume = ovalid_q && bus.oready;

  // Beat counter, staging buffer and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat     <= '0;
      busy_q   <= 1'b0;
      ovalid_q <= 1'b0;
      stage    <= '{default: '0};
      ostate   <= '{default: '0};
    end else begin
      if (accept) begin
        if (last) begin
          ostate <= merged;
          beat   <= '0;
          busy_q <= 1'b0;
        end else begin
          stage  <= merged;
          beat   <= beat + BW'(1);
          busy_q <= 1'b1;
        end
      end
      // A final accept wins over a same-cycle consume: the register reloads.
      if (accept && last) begin
        ovalid_q <= 1'b1;
      end else if (consume) begin
        ovalid_q <= 1'b0;
      end
    end
  end

  for (genvar c = 0; c < 5; c++) begin : g_out
    assign bus.osa[c] = ostate[0][c];
    assign bus.osb[c] = ostate[1][c];
    assign bus.osc[c] = ostate[2][c];
    assign bus.osd[c] = ostate[3][c];
    assign bus.ose[c] = ostate[4][c];
  end

  assign bus.ovalid = ovalid_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_sha3_theta_updater_stream.sv
// Bench for sha3_theta_updater_stream: three instances (64-bit serial,
// 64-bit parallel, 8-bit parallel), directed sequences, a vector table and a
// randomized run against a column-level reference model.
module tb_sha3_theta_updater_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sha3_theta_updater_stream_if #(.LANE_WIDTH(64), .COLS(1)) b1 ();
  sha3_theta_updater_stream_if #(.LANE_WIDTH(64), .COLS(5)) b5 ();
  sha3_theta_updater_stream_if #(.LANE_WIDTH(8),  .COLS(5)) b8 ();

  sha3_theta_updater_stream #(.LANE_WIDTH(64), .COLS(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  sha3_theta_updater_stream #(.LANE_WIDTH(64), .COLS(5)) u5 (.clk(clk), .rst(rst), .bus(b5.slave));
  sha3_theta_updater_stream #(.LANE_WIDTH(8),  .COLS(5)) u8 (.clk(clk), .rst(rst), .bus(b8.slave));

  typedef logic [63:0] col_t [5];
  typedef struct {
    logic [7:0] lane;
    logic [7:0] e;
    logic       byp;
    logic [7:0] want;
  } vec8_t;

  int passed = 0;
  int total  = 0;

  // Current serial state: per beat (column) c, five row lanes, D value, bypass.
  col_t        cin [5];
  logic [63:0] cel [5];
  logic        cby [5];
  logic [63:0] expa [5][5];
  logic [63:0] expb [5][5];
  logic [63:0] zero_st [5][5];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) $display("FAIL %s: got %h expected %h", name, got, want);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] o1(input int r, input int c);
    case (r)
      0: return b1.osa[3'(c)];
      1: return b1.osb[3'(c)];
      2: return b1.osc[3'(c)];
      3: return b1.osd[3'(c)];
      default: return b1.ose[3'(c)];
    endcase
  endfunction

  function automatic logic [63:0] o5(input int r, input int c);
    case (r)
      0: return b5.osa[3'(c)];
      1: return b5.osb[3'(c)];
      2: return b5.osc[3'(c)];
      3: return b5.osd[3'(c)];
      default: return b5.ose[3'(c)];
    endcase
  endfunction

  function automatic logic [63:0] o8(input int r, input int c);
    case (r)
      0: return 64'(b8.osa[3'(c)]);
      1: return 64'(b8.osb[3'(c)]);
      2: return 64'(b8.osc[3'(c)]);
      3: return 64'(b8.osd[3'(c)]);
      default: return 64'(b8.ose[3'(c)]);
    endcase
  endfunction

  task automatic set5(input int r, input int c, input logic [63:0] v);
    case (r)
      0: b5.isa[3'(c)] = v;
      1: b5.isb[3'(c)] = v;
      2: b5.isc[3'(c)] = v;
      3: b5.isd[3'(c)] = v;
      default: b5.ise[3'(c)] = v;
    endcase
  endtask

  task automatic set8(input int r, input int c, input logic [7:0] v);
    case (r)
      0: b8.isa[3'(c)] = v;
      1: b8.isb[3'(c)] = v;
      2: b8.isc[3'(c)] = v;
      3: b8.isd[3'(c)] = v;
      default: b8.ise[3'(c)] = v;
    endcase
  endtask

  task automatic put1(input logic [63:0] l [5], input logic [63:0] e, input logic byp, input logic v);
    b1.isa[0] = l[0];
    b1.isb[0] = l[1];
    b1.isc[0] = l[2];
    b1.isd[0] = l[3];
    b1.ise[0] = l[4];
    b1.elt[0] = e;
    b1.bypass = byp;
    b1.ivalid = v;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic rand_state(input logic all_ones_elt);
    for (int c = 0; c < 5; c++) begin
      for (int r = 0; r < 5; r++) cin[c][r] = rnd64();
      cel[c] = all_ones_elt ? '1 : rnd64();
      cby[c] = 1'b0;
    end
  endtask

  // Expected state straight from the rule out[r][c] = in[r][c] ^ D[c] (or 0).
  task automatic calc_exp(output logic [63:0] e [5][5]);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        e[r][c] = cin[c][r] ^ (cby[c] ? 64'h0 : cel[c]);
  endtask

  task automatic send1();
    for (int k = 0; k < 5; k++) begin
      put1(cin[k], cel[k], cby[k], 1'b1);
      step();
    end
    b1.ivalid = 1'b0;
  endtask

  task automatic chk_state1(input string tag, input logic [63:0] e [5][5]);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        chk($sformatf("%s[%0d][%0d]", tag, r, c), o1(r, c), e[r][c]);
  endtask

  // Randomized run: model state (column-level view of the protocol).
  int          m_cnt;
  logic        m_ov;
  logic [63:0] m_pend [5][5];
  logic [63:0] m_out  [5][5];

  initial begin
    vec8_t tv [4];
    logic [63:0] lane_v;
    logic [63:0] elt_v;
    logic        v;
    logic        or_v;
    logic        byp_v;
    logic        acc;
    logic        hold;
    logic        exp_ir;
    col_t        rl;
    logic [63:0] re;

    tv[0] = '{lane: 8'hFF, e: 8'hA5, byp: 1'b0, want: 8'h5A};
    tv[1] = '{lane: 8'h3C, e: 8'h0F, byp: 1'b0, want: 8'h33};
    tv[2] = '{lane: 8'h3C, e: 8'hFF, byp: 1'b1, want: 8'h3C};
    tv[3] = '{lane: 8'h00, e: 8'h81, byp: 1'b0, want: 8'h81};

    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) zero_st[r][c] = 64'h0;

    rst = 1'b1;
    b1.ivalid = 1'b0; b1.oready = 1'b0; b1.bypass = 1'b0;
    b5.ivalid = 1'b0; b5.oready = 1'b0; b5.bypass = 1'b0;
    b8.ivalid = 1'b0; b8.oready = 1'b0; b8.bypass = 1'b0;
    for (int c = 0; c < 5; c++) rl[c] = 64'h0;
    put1(rl, 64'h0, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      b5.elt[3'(c)] = 64'h0;
      b8.elt[3'(c)] = 8'h0;
      for (int r = 0; r < 5; r++) begin
        set5(r, c, 64'h0);
        set8(r, c, 8'h0);
      end
    end
    step();
    step();
    rst = 1'b0;

    // Reset state.
    chk("rst_ovalid", 64'(b1.ovalid), 64'h0);
    chk("rst_busy", 64'(b1.busy), 64'h0);
    chk("rst_iready", 64'(b1.iready), 64'h1);
    chk("rst_ovalid5", 64'(b5.ovalid), 64'h0);
    chk_state1("rst_lane", zero_st);

    // Full-parallel, one beat.
    for (int c = 0; c < 5; c++) begin
      b5.elt[3'(c)] = 64'hFFFF_0000_FFFF_0000 >> c;
      for (int r = 0; r < 5; r++) set5(r, c, 64'h0101_0101_0101_0101 * 64'(5 * r + c + 1));
    end
    b5.oready = 1'b1;
    b5.ivalid = 1'b1;
    #1;
    chk("par_iready", 64'(b5.iready), 64'h1);
    step();
    b5.ivalid = 1'b0;
    chk("par_ovalid", 64'(b5.ovalid), 64'h1);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        chk($sformatf("par[%0d][%0d]", r, c), o5(r, c),
            (64'h0101_0101_0101_0101 * 64'(5 * r + c + 1)) ^ (64'hFFFF_0000_FFFF_0000 >> c));
    step();
    chk("par_ovalid_drop", 64'(b5.ovalid), 64'h0);

    // 8-bit lane vector table.
    b8.oready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 5; c++) begin
        b8.elt[3'(c)] = tv[i].e;
        for (int r = 0; r < 5; r++) set8(r, c, tv[i].lane);
      end
      b8.bypass = tv[i].byp;
      b8.ivalid = 1'b1;
      step();
      b8.ivalid = 1'b0;
      chk($sformatf("w8_ovalid_%0d", i), 64'(b8.ovalid), 64'h1);
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          chk($sformatf("w8_%0d[%0d][%0d]", i, r, c), o8(r, c), 64'(tv[i].want));
      step();
    end

    // Column-serial state: busy pattern, iready, latency.
    rand_state(1'b0);
    b1.oready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      put1(cin[k], cel[k], 1'b0, 1'b1);
      #1;
      chk($sformatf("ser_busy_%0d", k), 64'(b1.busy), (k != 0) ? 64'h1 : 64'h0);
      chk($sformatf("ser_iready_%0d", k), 64'(b1.iready), 64'h1);
      chk($sformatf("ser_ovalid_%0d", k), 64'(b1.ovalid), 64'h0);
      step();
    end
    b1.ivalid = 1'b0;
    chk("ser_ovalid", 64'(b1.ovalid), 64'h1);
    calc_exp(expa);
    chk_state1("ser", expa);
    step();
    chk("ser_ovalid_drop", 64'(b1.ovalid), 64'h0);

    // Backpressure: A held, B stages beats 0-3, beat 4 waits for oready.
    b1.oready = 1'b0;
    rand_state(1'b0);
    send1();
    calc_exp(expa);
    chk("bp_a_valid", 64'(b1.ovalid), 64'h1);
    rand_state(1'b0);
    calc_exp(expb);
    for (int k = 0; k < 4; k++) begin
      put1(cin[k], cel[k], 1'b0, 1'b1);
      #1;
      chk($sformatf("bp_iready_%0d", k), 64'(b1.iready), 64'h1);
      step();
    end
    put1(cin[4], cel[4], 1'b0, 1'b1);
    #1;
    chk("bp_iready_4", 64'(b1.iready), 64'h0);
    chk_state1("bp_hold", expa);
    step();
    chk("bp_stall_valid", 64'(b1.ovalid), 64'h1);
    chk("bp_stall_busy", 64'(b1.busy), 64'h1);
    chk_state1("bp_stall", expa);
    b1.oready = 1'b1;
    #1;
    chk("bp_iready_release", 64'(b1.iready), 64'h1);
    step();
    b1.ivalid = 1'b0;
    b1.oready = 1'b0;
    chk("bp_b_valid", 64'(b1.ovalid), 64'h1);
    chk("bp_b_busy", 64'(b1.busy), 64'h0);
    chk_state1("bp_b", expb);
    b1.oready = 1'b1;
    step();
    chk("bp_drain", 64'(b1.ovalid), 64'h0);

    // Bypass on beats 1 and 3 with all-ones D.
    rand_state(1'b1);
    cby[1] = 1'b1;
    cby[3] = 1'b1;
    send1();
    calc_exp(expa);
    chk("byp_col1", o1(2, 1), cin[1][2]);
    chk("byp_col0", o1(2, 0), ~cin[0][2]);
    chk_state1("byp", expa);
    step();

    // Reset mid-state, then a fresh state.
    rand_state(1'b0);
    for (int k = 0; k < 3; k++) begin
      put1(cin[k], cel[k], 1'b0, 1'b1);
      step();
    end
    b1.ivalid = 1'b0;
    chk("mid_busy_pre", 64'(b1.busy), 64'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_busy", 64'(b1.busy), 64'h0);
    chk("mid_ovalid", 64'(b1.ovalid), 64'h0);
    chk_state1("mid_zero", zero_st);
    rand_state(1'b0);
    for (int c = 0; c < 5; c++) cby[c] = 1'(c % 2);
    send1();
    calc_exp(expa);
    chk("mid_fresh_valid", 64'(b1.ovalid), 64'h1);
    chk_state1("mid_fresh", expa);

    // Randomized handshake run against the column-level model.
    rst = 1'b1;
    b1.ivalid = 1'b0;
    step();
    rst = 1'b0;
    m_cnt = 0;
    m_ov  = 1'b0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        m_pend[r][c] = 64'h0;
        m_out[r][c]  = 64'h0;
      end
    hold  = 1'b0;
    v     = 1'b0;
    byp_v = 1'b0;
    re    = 64'h0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (!hold) begin
        v     = ($urandom_range(0, 3) != 0);
        byp_v = ($urandom_range(0, 3) == 0);
        for (int r = 0; r < 5; r++) rl[r] = rnd64();
        re = rnd64();
      end
      or_v = ($urandom_range(0, 9) < 6);
      put1(rl, re, byp_v, v);
      b1.oready = or_v;
      #1;
      exp_ir = (m_cnt != 4) || !m_ov || or_v;
      chk("rnd_iready", 64'(b1.iready), 64'(exp_ir));
      chk("rnd_busy", 64'(b1.busy), (m_cnt != 0) ? 64'h1 : 64'h0);
      chk("rnd_ovalid", 64'(b1.ovalid), 64'(m_ov));
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          chk($sformatf("rnd[%0d][%0d]", r, c), o1(r, c), m_out[r][c]);
      acc = v && exp_ir;
      if (acc) begin
        elt_v = byp_v ? 64'h0 : re;
        for (int r = 0; r < 5; r++) begin
          lane_v = rl[r] ^ elt_v;
          m_pend[r][m_cnt] = lane_v;
        end
        if (m_cnt == 4) begin
          m_out = m_pend;
          m_cnt = 0;
          m_ov  = 1'b1;
        end else begin
          m_cnt = m_cnt + 1;
          if (m_ov && or_v) m_ov = 1'b0;
        end
      end else if (m_ov && or_v) begin
        m_ov = 1'b0;
      end
      hold = v && !acc;
      step();
    end
    b1.ivalid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
